// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush controller for the 5-stage RV32IM pipeline.
// Resolves load-use, branch, memory busywait and multi-cycle DIV/REM hazards.
module pipeline_hazard_controller #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_div_start,
  input  logic             branch_taken,
  input  logic             imem_busywait,
  input  logic             dmem_busywait,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DCW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_CYCLES - 2);

  typedef enum logic {RUN, DIV_WAIT} state_t;

  state_t         state;
  logic [DCW-1:0] div_cnt;
  logic           load_use;

  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

  // Only the highest-priority active condition drives the controls.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_stall = 1'b0;
    div_busy     = reset && (state == DIV_WAIT);
    if (reset) begin
      if (dmem_busywait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end else if ((state == DIV_WAIT) || ex_div_start) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (imem_busywait) begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
      end
    end
  end

  // The start cycle itself is one stall, so DIV_WAIT covers the remaining DIV_CYCLES-2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      div_cnt     <= '0;
      stall_count <= '0;
    end else begin
      if (pc_stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (!dmem_busywait) begin
        if (state == DIV_WAIT) begin
          div_cnt <= div_cnt - DCW'(1);
          if (div_cnt <= DCW'(1))
            state <= RUN;
        end else if (ex_div_start && (DIV_CYCLES > 2)) begin
          state   <= DIV_WAIT;
          div_cnt <= DIV_LOAD;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: table vectors, DIV/reset/saturation sequences
// and random stimulus against a priority-rule model.
module tb_pipeline_hazard_controller;

  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_div_start = 0;
  logic       branch_taken = 0, imem_busywait = 0, dmem_busywait = 0;

  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, div_busy;
  logic [CNT_W-1:0] stall_count;

  logic s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
  logic s_ex_mem_stall, s_ex_mem_flush, s_mem_wb_stall, s_div_busy;
  logic [3:0] s_stall_count;

  pipeline_hazard_controller #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_div_start(ex_div_start), .branch_taken(branch_taken),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .ex_mem_flush(ex_mem_flush), .mem_wb_stall(mem_wb_stall), .div_busy(div_busy),
    .stall_count(stall_count)
  );

  // Small build: 4-bit counter and the shortest legal divide.
  pipeline_hazard_controller #(.DIV_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_div_start(ex_div_start), .branch_taken(branch_taken),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush), .ex_mem_stall(s_ex_mem_stall),
    .ex_mem_flush(s_ex_mem_flush), .mem_wb_stall(s_mem_wb_stall), .div_busy(s_div_busy),
    .stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  logic [8:0] dut_vec, sat_vec;
  assign dut_vec = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                    ex_mem_stall, ex_mem_flush, mem_wb_stall, div_busy};
  assign sat_vec = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush,
                    s_ex_mem_stall, s_ex_mem_flush, s_mem_wb_stall, s_div_busy};

  int vectors = 0;
  int miscompares = 0;
  int pc_cycles = 0;
  int busy_cycles = 0;

  int     div_left = 0;
  longint model_count = 0;
  bit     model_in_reset = 1'b1;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Expected {pc,ifs,iff,ids,idf,exs,exf,mws,busy} from the priority rules.
  function automatic logic [8:0] model_outputs();
    logic lu;
    logic [8:0] o;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    o = '0;
    if (model_in_reset) return o;
    if (dmem_busywait)                  o = 9'b110101010;
    else if (div_left > 0 || ex_div_start) o = 9'b110100100;
    else if (branch_taken)              o = 9'b001010000;
    else if (lu)                        o = 9'b110010000;
    else if (imem_busywait)             o = 9'b101000000;
    o[0] = (div_left > 0);
    return o;
  endfunction

  function automatic void model_edge();
    logic [8:0] o;
    if (model_in_reset) return;
    o = model_outputs();
    if (o[8] && model_count < CNT_MAX) model_count++;
    if (dmem_busywait) return;
    if (div_left > 0) div_left--;
    else if (ex_div_start && DIV_CYCLES > 2) div_left = DIV_CYCLES - 2;
  endfunction

  task automatic check_value(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [8:0] got, input logic [8:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: outputs got %b expected %b", name, got, exp);
    end
  endtask

  // Entered at a falling edge: check, clock once, advance the model.
  task automatic apply_stimulus(input string name);
    #1;
    check_output(name, dut_vec, model_outputs());
    check_value({name, " stall_count"}, longint'(stall_count), model_count);
    if (pc_stall) pc_cycles++;
    if (div_busy) busy_cycles++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_inputs(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                            input logic u2, input logic [4:0] rd, input logic mr,
                            input logic ds, input logic br, input logic im, input logic dm);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2; ex_rd = rd;
    ex_mem_read = mr; ex_div_start = ds; branch_taken = br;
    imem_busywait = im; dmem_busywait = dm;
  endtask

  task automatic idle();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_in_reset = 1'b1;
    div_left = 0;
    model_count = 0;
    #1;
    check_output("reset outputs", dut_vec, 9'b0);
    check_value("reset stall_count", longint'(stall_count), 0);
    @(negedge clk);
    reset = 1'b1;
    model_in_reset = 1'b0;
    pc_cycles = 0;
    busy_cycles = 0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, br, im, dm;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // rs1, rs2, rd, u1, u2, mr, br, im, dm, {pc,ifs,iff,ids,idf,exs,exf,mws}
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 8'b00000000};
    tbl[1]  = '{5'd1, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 8'b11001000};
    tbl[2]  = '{5'd1, 5'd5, 5'd0, 0, 1, 1, 0, 0, 0, 8'b00000000};
    tbl[3]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 8'b00000000};
    tbl[4]  = '{5'd7, 5'd2, 5'd7, 0, 1, 1, 0, 0, 0, 8'b00000000};
    tbl[5]  = '{5'd7, 5'd2, 5'd7, 1, 0, 1, 0, 0, 0, 8'b11001000};
    tbl[6]  = '{5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0, 8'b00000000};
    tbl[7]  = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, 0, 8'b00101000};
    tbl[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 8'b10100000};
    tbl[9]  = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 0, 1, 0, 8'b11001000};
    tbl[10] = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 1, 1, 1, 8'b11010101};

    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      set_inputs(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
                 tbl[i].mr, 1'b0, tbl[i].br, tbl[i].im, tbl[i].dm);
      #1;
      check_output($sformatf("table[%0d]", i), {1'b0, dut_vec[8:1]}, {1'b0, tbl[i].exp});
      apply_stimulus($sformatf("table[%0d] model", i));
    end

    // Plain DIV: 32 stall cycles, 31 busy cycles.
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    apply_stimulus("div start");
    idle();
    for (int i = 0; i < 40; i++) apply_stimulus("div wait");
    check_value("div pc_stall cycles", pc_cycles, 32);
    check_value("div busy cycles", busy_cycles, 31);
    check_value("div stall_count", longint'(stall_count), 32);

    // DIV interrupted by 5 data-memory busywait cycles.
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply_stimulus("divdm start");
    idle();
    for (int i = 0; i < 10; i++) apply_stimulus("divdm wait");
    for (int i = 0; i < 5; i++) begin
      set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      apply_stimulus("divdm busywait");
    end
    idle();
    for (int i = 0; i < 40; i++) apply_stimulus("divdm tail");
    check_value("divdm pc_stall cycles", pc_cycles, 37);
    check_value("divdm busy cycles", busy_cycles, 36);
    check_value("divdm stall_count", longint'(stall_count), 37);

    // Asynchronous reset in DIV_WAIT with 10 cycles left.
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    apply_stimulus("arst start");
    idle();
    for (int i = 0; i < 21; i++) apply_stimulus("arst wait");
    check_value("arst div_left", div_left, 10);
    #2;
    reset = 1'b0;
    model_in_reset = 1'b1;
    div_left = 0;
    model_count = 0;
    #1;
    check_output("arst outputs", dut_vec, 9'b0);
    check_value("arst stall_count", longint'(stall_count), 0);
    @(negedge clk);
    reset = 1'b1;
    model_in_reset = 1'b0;
    apply_stimulus("arst after release");
    set_inputs(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    apply_stimulus("arst branch in RUN");

    // Saturation and single-cycle DIV on the small build.
    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 19; i++) begin
      if (i == 14) begin
        #1;
        check_value("sat count 14", longint'(s_stall_count), 14);
      end
      apply_stimulus("sat imem");
    end
    #1;
    check_value("sat count saturated", longint'(s_stall_count), 15);

    do_reset();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    check_output("div2 start", sat_vec, 9'b110100100);
    apply_stimulus("div2 start main");
    idle();
    #1;
    check_output("div2 after", sat_vec, 9'b0);
    apply_stimulus("div2 after main");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_inputs(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      apply_stimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush controller for the 5-stage RV32IM pipeline; drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use hazards, taken branches/jumps, instruction- and data-memory busywait, and multi-cycle DIV/REM operations.
- Sequences multi-cycle DIV/REM with an internal FSM and cycle counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
DIV_CYCLES, 33, total EX-stage occupancy of a DIV/DIVU/REM/REMU (>=2)
CNT_W, 32, width of stall_count

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_div_start  input  1  EX holds a DIV/REM entering EX this cycle
branch_taken  input  1  EX resolved a taken branch/jump this cycle
imem_busywait  input  1  instruction memory not ready
dmem_busywait  input  1  data memory not ready
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  load NOP into IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load bubble into ID/EX
ex_mem_stall  output  1  hold EX/MEM
ex_mem_flush  output  1  load bubble into EX/MEM
mem_wb_stall  output  1  hold MEM/WB
div_busy  output  1  FSM in DIV_WAIT
stall_count  output  CNT_W  cycles with pc_stall=1, saturating

Behaviour:
- State: FSM {RUN, DIV_WAIT}, down-counter div_cnt (clog2(DIV_CYCLES) bits), and stall_count. All of these are registered.
- All stall/flush outputs are combinational from the current state and inputs. They have zero-cycle latency and are valid in the same cycle as the triggering input.
- Reset (reset=0, asynchronous, any time including mid-DIV): state=RUN, div_cnt=0, stall_count=0. While reset is low, all stall/flush outputs and div_busy are 0.
- Load-use hazard (lu) = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority, highest first; only the highest active condition applies:
  1. dmem_busywait=1: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_stall are all 1. No flushes. div_cnt holds (no decrement). FSM holds.
  2. state=DIV_WAIT: pc_stall, if_id_stall and id_ex_stall are 1; ex_mem_flush=1 (bubble into MEM); div_busy=1. Each cycle div_cnt decrements. When div_cnt==1, the next state is RUN, and the DIV result advances on the following edge. branch_taken and lu are ignored in this state.
  3. RUN & ex_div_start=1: ex_div_start takes precedence over branch_taken. Outputs are the same as in DIV_WAIT. The next state is DIV_WAIT with div_cnt=DIV_CYCLES-2, so total stall is DIV_CYCLES-1 cycles. If DIV_CYCLES==2, the FSM stays RUN after one stall cycle.
  4. RUN & branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_stall=0 so the target is loaded. This applies even if imem_busywait=1 or lu=1.
  5. RUN & lu=1: pc_stall=1, if_id_stall=1, id_ex_flush=1 (a single bubble). The hazard clears on the next edge once the load moves to MEM.
  6. RUN & imem_busywait=1: pc_stall=1, if_id_flush=1, so the ID stage never re-decodes a duplicate instruction.
  7. Otherwise: all stall/flush outputs are 0.
- A stall and a flush are never both asserted on the same register.
- stall_count increments by 1 on each edge where pc_stall=1, and saturates at all-ones.
- Unlisted input combinations in DIV_WAIT, such as a new ex_div_start, are ignored.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5); ID has id_rs2=5 with id_uses_rs2=1 → for 1 cycle pc_stall=1, if_id_stall=1, id_ex_flush=1. With ex_rd=0 the same stimulus → no stall.
- ex_div_start=1 for one cycle with DIV_CYCLES=33 → pc_stall=1 for exactly 32 cycles, div_busy=1 for 31 cycles, then RUN; stall_count=32.
- DIV in progress, dmem_busywait=1 for 5 cycles mid-wait → all five stage stalls are 1 and the counter freezes; total pc_stall cycles = 37.
- branch_taken=1 together with lu=1 and imem_busywait=1 → if_id_flush=1, id_ex_flush=1, pc_stall=0, if_id_stall=0.
- reset driven to 0 asynchronously (between clock edges) while in DIV_WAIT with div_cnt=10 → outputs go to 0 immediately. After reset rises, state=RUN and stall_count=0.
- Hold imem_busywait=1 for 2^CNT_W+3 cycles (CNT_W=4 build) → stall_count saturates at 15.
